// File: rtl/jam_cost_server.sv
// jam_cost_server: cost-table responder that sits beside JAM.
// A 66-word stream loads the 8x8 worker/job cost table and the golden
// MinCost/MatchCount. The block then holds JAM out of reset, answers every
// (W,J) request with its cost one cycle later, and captures and grades
// JAM's result when Valid rises, or declares a timeout. Results are held
// until CLR returns the block to LOAD for the next pattern.
module jam_cost_server #(
  parameter int TIMEOUT = 10000000,
  parameter int CNT_W   = 24
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LD_VALID,
  input  logic [8:0]       LD_DATA,
  output logic             LD_READY,
  input  logic             CLR,
  output logic             JAM_RST,
  input  logic [2:0]       W,
  input  logic [2:0]       J,
  output logic [6:0]       Cost,
  input  logic             Valid,
  input  logic [8:0]       MinCost,
  input  logic [3:0]       MatchCount,
  output logic             DONE,
  output logic             PASS,
  output logic             TIMEOUT_FLAG,
  output logic [8:0]       CAP_MIN,
  output logic [3:0]       CAP_CNT,
  output logic [CNT_W-1:0] CYCLES
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Timeout threshold expressed in the counter's own width.
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  // Word positions within the load stream.
  localparam logic [6:0] IDX_GOLD_MIN = 7'd64;
  localparam logic [6:0] IDX_GOLD_CNT = 7'd65;

  state_t           state_q, state_d;
  logic [6:0]       idx_q, idx_d;
  logic [8:0]       gold_min_q, gold_min_d;
  logic [3:0]       gold_cnt_q, gold_cnt_d;
  logic [2:0]       w_s_q, w_s_d;
  logic [2:0]       j_s_q, j_s_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             pass_q, pass_d;
  logic             tmo_q, tmo_d;
  logic [8:0]       cap_min_q, cap_min_d;
  logic [3:0]       cap_cnt_q, cap_cnt_d;
  logic             jam_rst_q, jam_rst_d;

  logic             tbl_we;
  logic [5:0]       tbl_waddr;
  logic [6:0]       cost_mem [64];

  // Next-state logic: load sequencing, run supervision and result grading.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gold_min_d = gold_min_q;
    gold_cnt_d = gold_cnt_q;
    w_s_d      = W;
    j_s_d      = J;
    cycles_d   = cycles_q;
    pass_d     = pass_q;
    tmo_d      = tmo_q;
    cap_min_d  = cap_min_q;
    cap_cnt_d  = cap_cnt_q;
    tbl_we     = 1'b0;
    tbl_waddr  = idx_q[5:0];

    unique case (state_q)
      ST_LOAD: begin
        if (LD_VALID) begin
          idx_d = idx_q + 7'd1;
          if (idx_q < IDX_GOLD_MIN) begin
            tbl_we = 1'b1;
          end else if (idx_q == IDX_GOLD_MIN) begin
            gold_min_d = LD_DATA;
          end else if (idx_q == IDX_GOLD_CNT) begin
            gold_cnt_d = LD_DATA[3:0];
            state_d    = ST_RUN;
          end else begin
            state_d    = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        cycles_d = cycles_q + CNT_W'(1);
        // A result arriving on the timeout edge still counts as a result.
        if (Valid) begin
          cap_min_d = MinCost;
          cap_cnt_d = MatchCount;
          pass_d    = (MinCost == gold_min_q) && (MatchCount == gold_cnt_q);
          state_d   = ST_DONE;
        end else if (cycles_d == TIMEOUT_C) begin
          tmo_d     = 1'b1;
          pass_d    = 1'b0;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        if (CLR) begin
          idx_d     = '0;
          cycles_d  = '0;
          pass_d    = 1'b0;
          tmo_d     = 1'b0;
          cap_min_d = '0;
          cap_cnt_d = '0;
          state_d   = ST_LOAD;
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase

    // JAM is released only while the block is actually serving costs.
    jam_rst_d = (state_d != ST_RUN);
  end

  // State and status registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_LOAD;
      idx_q      <= '0;
      gold_min_q <= '0;
      gold_cnt_q <= '0;
      w_s_q      <= '0;
      j_s_q      <= '0;
      cycles_q   <= '0;
      pass_q     <= 1'b0;
      tmo_q      <= 1'b0;
      cap_min_q  <= '0;
      cap_cnt_q  <= '0;
      jam_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gold_min_q <= gold_min_d;
      gold_cnt_q <= gold_cnt_d;
      w_s_q      <= w_s_d;
      j_s_q      <= j_s_d;
      cycles_q   <= cycles_d;
      pass_q     <= pass_d;
      tmo_q      <= tmo_d;
      cap_min_q  <= cap_min_d;
      cap_cnt_q  <= cap_cnt_d;
      jam_rst_q  <= jam_rst_d;
    end
  end

  // Cost table RAM: not reset, and no writes while reset is held.
  always_ff @(posedge CLK) begin
    if (tbl_we && !RST) begin
      cost_mem[tbl_waddr] <= LD_DATA[6:0];
    end
  end

  // Registered (W,J) address drives the lookup; zero outside RUN.
  always_comb begin
    Cost = '0;
    if (state_q == ST_RUN) begin
      Cost = cost_mem[{w_s_q, j_s_q}];
    end
  end

  assign LD_READY     = (state_q == ST_LOAD);
  assign DONE         = (state_q == ST_DONE);
  assign JAM_RST      = jam_rst_q;
  assign PASS         = pass_q;
  assign TIMEOUT_FLAG = tmo_q;
  assign CAP_MIN      = cap_min_q;
  assign CAP_CNT      = cap_cnt_q;
  assign CYCLES       = cycles_q;

endmodule

// File: tb/tb_jam_cost_server.sv
// Testbench for jam_cost_server: directed load/run/clear scenarios, with a
// transaction-level model of the load stream, run and grading checked
// against the DUT on every falling edge.
module tb_jam_cost_server;

  localparam int TMO = 100;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ld_valid = 1'b0;
  logic [8:0]    ld_data = '0;
  logic          clr = 1'b0;
  logic [2:0]    w = '0;
  logic [2:0]    j = '0;
  logic          valid = 1'b0;
  logic [8:0]    min_cost = '0;
  logic [3:0]    match_count = '0;

  logic          ld_ready;
  logic          jam_rst;
  logic [6:0]    cost;
  logic          done;
  logic          pass;
  logic          tmo_flag;
  logic [8:0]    cap_min;
  logic [3:0]    cap_cnt;
  logic [CW-1:0] cycles;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [6:0] pat [64];

  // Model state: 0 = loading, 1 = running, 2 = finished.
  int m_phase = 0;
  int m_words = 0;
  int m_cyc = 0;
  int m_tbl [64];
  int m_gmin = 0;
  int m_gcnt = 0;
  int m_pass = 0;
  int m_tmo = 0;
  int m_cap_min = 0;
  int m_cap_cnt = 0;
  int m_w = 0;
  int m_j = 0;

  jam_cost_server #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .CLK(clk),
    .RST(rst),
    .LD_VALID(ld_valid),
    .LD_DATA(ld_data),
    .LD_READY(ld_ready),
    .CLR(clr),
    .JAM_RST(jam_rst),
    .W(w),
    .J(j),
    .Cost(cost),
    .Valid(valid),
    .MinCost(min_cost),
    .MatchCount(match_count),
    .DONE(done),
    .PASS(pass),
    .TIMEOUT_FLAG(tmo_flag),
    .CAP_MIN(cap_min),
    .CAP_CNT(cap_cnt),
    .CYCLES(cycles)
  );

  always #5 clk = ~clk;

  // Transaction-level model of the server, advanced on each clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_words = 0; m_cyc = 0; m_pass = 0; m_tmo = 0;
      m_cap_min = 0; m_cap_cnt = 0; m_w = 0; m_j = 0; m_gmin = 0; m_gcnt = 0;
    end else begin
      if (m_phase == 0) begin
        if (ld_valid) begin
          if (m_words < 64) m_tbl[m_words] = int'(ld_data[6:0]);
          else if (m_words == 64) m_gmin = int'(ld_data);
          else begin
            m_gcnt = int'(ld_data[3:0]);
            m_phase = 1;
          end
          m_words++;
        end
      end else if (m_phase == 1) begin
        m_cyc++;
        if (valid) begin
          m_cap_min = int'(min_cost);
          m_cap_cnt = int'(match_count);
          m_pass = (int'(min_cost) == m_gmin && int'(match_count) == m_gcnt) ? 1 : 0;
          m_phase = 2;
        end else if (m_cyc == TMO) begin
          m_tmo = 1;
          m_pass = 0;
          m_phase = 2;
        end
      end else if (clr) begin
        m_phase = 0; m_words = 0; m_cyc = 0; m_pass = 0; m_tmo = 0;
        m_cap_min = 0; m_cap_cnt = 0;
      end
      m_w = int'(w);
      m_j = int'(j);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output with the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("m_ld_ready", 32'(ld_ready), 32'(m_phase == 0));
      checkOutput("m_jam_rst", 32'(jam_rst), 32'(m_phase != 1));
      checkOutput("m_done", 32'(done), 32'(m_phase == 2));
      checkOutput("m_pass", 32'(pass), 32'(m_pass));
      checkOutput("m_timeout", 32'(tmo_flag), 32'(m_tmo));
      checkOutput("m_cap_min", 32'(cap_min), 32'(m_cap_min));
      checkOutput("m_cap_cnt", 32'(cap_cnt), 32'(m_cap_cnt));
      checkOutput("m_cycles", 32'(cycles), 32'(m_cyc));
      if (m_phase != 1) checkOutput("m_cost_idle", 32'(cost), 32'd0);
      else if (m_cyc >= 1) checkOutput("m_cost", 32'(cost), 32'(m_tbl[m_w * 8 + m_j]));
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ld_ready"}, 32'(ld_ready), 32'd1);
    checkOutput({tag, "_jam_rst"}, 32'(jam_rst), 32'd1);
    checkOutput({tag, "_cost"}, 32'(cost), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_pass"}, 32'(pass), 32'd0);
    checkOutput({tag, "_timeout"}, 32'(tmo_flag), 32'd0);
    checkOutput({tag, "_cap_min"}, 32'(cap_min), 32'd0);
    checkOutput({tag, "_cap_cnt"}, 32'(cap_cnt), 32'd0);
    checkOutput({tag, "_cycles"}, 32'(cycles), 32'd0);
  endtask

  // Drive one load-stream cycle; called and returns just after a falling edge.
  task automatic applyStimulus(input logic v, input logic [8:0] d);
    ld_valid = v;
    ld_data  = d;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic fillPattern(input int kind);
    for (int i = 0; i < 64; i++) begin
      case (kind)
        0: pat[i] = 7'(i);
        1: pat[i] = 7'(63 - i);
        2: pat[i] = 7'((i * 37 + 11) % 128);
        default: pat[i] = 7'($urandom_range(0, 127));
      endcase
    end
  endtask

  // Stream the full pattern; upper bits of the table words carry junk.
  task automatic loadPattern(input int gmin, input int gcnt, input bit gaps);
    for (int i = 0; i < 66; i++) begin
      logic [8:0] d;
      if (i < 64) d = {2'($urandom_range(0, 3)), pat[i]};
      else if (i == 64) d = 9'(gmin);
      else begin
        checkOutput("jam_rst_before_last", 32'(jam_rst), 32'd1);
        checkOutput("ld_ready_before_last", 32'(ld_ready), 32'd1);
        d = {5'b10110, 4'(gcnt)};
      end
      applyStimulus(1'b1, d);
      if (gaps && i < 65) applyStimulus(1'b0, 9'h1ff);
    end
    checkOutput("jam_rst_first_run", 32'(jam_rst), 32'd0);
    checkOutput("ld_ready_in_run", 32'(ld_ready), 32'd0);
  endtask

  task automatic runCycles(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      int a;
      a = (base + i) % 64;
      w = 3'(a / 8);
      j = 3'(a % 8);
      @(negedge clk);
    end
  endtask

  task automatic sendResult(input int mc, input int cnt);
    valid = 1'b1;
    min_cost = 9'(mc);
    match_count = 4'(cnt);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic doClear;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("clr_ld_ready", 32'(ld_ready), 32'd1);
    checkOutput("clr_done", 32'(done), 32'd0);
    checkOutput("clr_cycles", 32'(cycles), 32'd0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1 checkResetValues("reset");
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;

    // Identity table, golden 0/1, back-to-back load.
    fillPattern(0);
    loadPattern(0, 1, 1'b0);
    w = 3'd3; j = 3'd5;
    @(negedge clk);
    checkOutput("cost_3_5", 32'(cost), 32'd29);
    w = 3'd7; j = 3'd7;
    @(negedge clk);
    checkOutput("cost_7_7", 32'(cost), 32'd63);
    runCycles(64, 0);
    sendResult(0, 1);
    checkOutput("t1_pass", 32'(pass), 32'd1);
    checkOutput("t1_cycles", 32'(cycles), 32'd67);
    doClear();

    // Reversed table, golden 120/2, gapped load, result on RUN edge 40.
    fillPattern(1);
    loadPattern(120, 2, 1'b1);
    clr = 1'b1;
    runCycles(1, 5);
    clr = 1'b0;
    runCycles(38, 6);
    sendResult(120, 2);
    checkOutput("t2_done", 32'(done), 32'd1);
    checkOutput("t2_pass", 32'(pass), 32'd1);
    checkOutput("t2_cap_min", 32'(cap_min), 32'd120);
    checkOutput("t2_cap_cnt", 32'(cap_cnt), 32'd2);
    checkOutput("t2_cycles", 32'(cycles), 32'd40);
    checkOutput("t2_jam_rst", 32'(jam_rst), 32'd1);
    valid = 1'b1; min_cost = 9'd7; match_count = 4'd9;
    runCycles(3, 0);
    valid = 1'b0;
    checkOutput("t2_hold_cycles", 32'(cycles), 32'd40);
    checkOutput("t2_hold_cap_min", 32'(cap_min), 32'd120);
    doClear();

    // New table and golden; wrong MinCost must fail the grade.
    fillPattern(2);
    loadPattern(121, 3, 1'b0);
    runCycles(1, 9);
    checkOutput("t3_cycles_restart", 32'(cycles), 32'd1);
    runCycles(38, 10);
    sendResult(120, 3);
    checkOutput("t3_pass", 32'(pass), 32'd0);
    checkOutput("t3_cap_min", 32'(cap_min), 32'd120);
    checkOutput("t3_cycles", 32'(cycles), 32'd40);
    doClear();

    // Timeout with no result.
    loadPattern(50, 4, 1'b0);
    runCycles(99, 0);
    checkOutput("t4_not_done", 32'(done), 32'd0);
    runCycles(1, 0);
    checkOutput("t4_done", 32'(done), 32'd1);
    checkOutput("t4_timeout", 32'(tmo_flag), 32'd1);
    checkOutput("t4_pass", 32'(pass), 32'd0);
    checkOutput("t4_cycles", 32'(cycles), 32'd100);
    doClear();

    // Result on the timeout edge wins.
    loadPattern(50, 4, 1'b0);
    runCycles(99, 20);
    sendResult(50, 4);
    checkOutput("t5_done", 32'(done), 32'd1);
    checkOutput("t5_timeout", 32'(tmo_flag), 32'd0);
    checkOutput("t5_pass", 32'(pass), 32'd1);
    checkOutput("t5_cycles", 32'(cycles), 32'd100);
    doClear();

    // Reset part-way through a load, then a full reload and address sweep.
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, {2'b00, pat[i]});
    #2 rst = 1'b1;
    #1 checkResetValues("midload");
    @(negedge clk);
    rst = 1'b0;
    fillPattern(3);
    loadPattern(300, 9, 1'b0);
    runCycles(64, 0);
    sendResult(300, 9);
    checkOutput("t6_pass", 32'(pass), 32'd1);
    checkOutput("t6_cycles", 32'(cycles), 32'd65);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jam_cost_server.md
# jam_cost_server

Synthesizable responder for the JAM cost-lookup interface. It holds the 8×8 worker/job cost table and golden results, loaded over a simple stream. It sequences JAM's reset, answers every `W`/`J` request with `Cost` one cycle later, and captures and checks `MinCost`/`MatchCount` when JAM raises `Valid`. It sits beside JAM at top level in place of a behavioural cost ROM, so the same pattern flow runs on FPGA or in gate-level regression.

## Interface
- `TIMEOUT`, default 10000000: RUN-state cycle limit before a timeout is declared.
- `CNT_W`, default 24: width of the cycle counter; must satisfy 2^CNT_W > TIMEOUT.
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `LD_VALID`  in  1  load word valid.
- `LD_DATA`  in  9  load word.
- `LD_READY`  out  1  high in LOAD state only.
- `CLR`  in  1  in DONE, returns block to LOAD for next pattern.
- `JAM_RST`  out  1  reset driven to JAM.
- `W`  in  3  worker index from JAM.
- `J`  in  3  job index from JAM.
- `Cost`  out  7  cost for the previously sampled (W,J).
- `Valid`  in  1  JAM result valid.
- `MinCost`  in  9  JAM result.
- `MatchCount`  in  4  JAM result.
- `DONE`, `PASS`, `TIMEOUT_FLAG`  out  1 each  run status.
- `CAP_MIN`  out  9  captured `MinCost`.
- `CAP_CNT`  out  4  captured `MatchCount`.
- `CYCLES`  out  CNT_W  RUN cycles elapsed.

## Operation
- States: LOAD, RUN, DONE. Reset enters LOAD.
- LOAD:
  - A transfer occurs on a `CLK` edge with `LD_VALID`=1 and `LD_READY`=1.
  - A 7-bit word index starts at 0 and increments per transfer.
  - Index 0–63 writes `LD_DATA[6:0]` to table[index]; entry address = 8*worker + job, row-major.
  - Index 64 writes golden MinCost from `LD_DATA[8:0]`.
  - Index 65 writes golden MatchCount from `LD_DATA[3:0]`, then moves to RUN.
  - Unused upper bits are ignored.
- RUN:
  - `W_s`/`J_s` registers sample `W`/`J` every edge.
  - `Cost` = table[8*W_s + J_s], combinational from the registers.
  - `CYCLES` increments every RUN cycle.
  - The first edge with `Valid`=1 captures `MinCost`→`CAP_MIN` and `MatchCount`→`CAP_CNT`, sets `PASS` = (both equal golden), and goes to DONE.
  - If instead `CYCLES` reaches `TIMEOUT` on that edge: `TIMEOUT_FLAG`=1, `PASS`=0, go to DONE.
  - If `Valid` and the timeout occur on the same edge, `Valid` wins.
- DONE:
  - All status and captured outputs hold.
  - `CYCLES` freezes.
  - `Valid` is ignored.
  - `CLR`=1 clears `DONE`, `PASS`, `TIMEOUT_FLAG`, `CAP_*`, `CYCLES` and the word index, then enters LOAD.
  - Table contents are retained but are fully overwritten by the next load.
- `CLR` outside DONE is ignored. `LD_VALID` outside LOAD is ignored.
- `Cost` is forced to 0 outside RUN.

## Timing
- Reset values: state LOAD, `LD_READY`=1, `JAM_RST`=1, `Cost`=0, `W_s`=`J_s`=0, and all status/capture/`CYCLES`=0. Table RAM is not reset.
- `JAM_RST` is registered: 1 in LOAD and DONE. It drops to 0 the cycle after the index-65 transfer, which is the first RUN cycle. It rises to 1 the cycle after `Valid`/timeout.
- Lookup latency: (W,J) sampled at edge N drive `Cost` during cycle N+1, valid before edge N+1. JAM issues an address and reads `Cost` at the following edge.
- The `CYCLES` value on the first RUN cycle after the update edge is 1. A `Valid` seen on the k-th RUN edge leaves `CYCLES`=k.
- `DONE` asserts the cycle after the deciding edge. `LD_READY` asserts the cycle after `CLR`.
- Back-to-back load transfers are accepted every cycle. Gaps in `LD_VALID` are allowed.
- `RST` mid-load or mid-run aborts immediately and asynchronously to the reset values. The partial table is kept but is not trusted.

## Test plan
- Load table[i]=i (0..63), golden 0/1; then drive W=3,J=5 at edge N -> `Cost`=29 during cycle N+1. Changing to W=7,J=7 -> 63 the next cycle.
- Load 66 words with `LD_VALID` toggling every other cycle -> exactly 66 transfers; `JAM_RST` falls one cycle after the last; `LD_READY`=0 in RUN.
- RUN, golden 120/2; raise `Valid` on RUN edge 40 with 120/2 -> `DONE`=1, `PASS`=1, `CAP_MIN`=120, `CAP_CNT`=2, `CYCLES`=40, `JAM_RST`=1. Repeat with 121/2 -> `PASS`=0.
- `TIMEOUT`=50, never raise `Valid` -> `DONE`=1, `TIMEOUT_FLAG`=1, `PASS`=0, `CYCLES`=50. Same with `Valid` on edge 50 -> `TIMEOUT_FLAG`=0.
- Assert `RST` after 30 load words -> all reset values. Full reload then run gives correct `Cost` for all 64 addresses.
- After DONE, pulse `CLR`, reload a different table and golden -> second run checks against the new golden; `CYCLES` restarts from 1.
